// File: rtl/spi_reg_bridge_if.sv
// Bus bundle for spi_reg_bridge: the SPI pins on one side, the single-cycle
// register-bus strobe on the other.
//
// Handshake: the register bus has no ready. reg_en is a one-clk strobe that
// the register file must always accept. While reg_en=1, reg_addr and reg_wr are
// valid, and on writes reg_be and reg_d are valid too. For a read, reg_q must
// hold the addressed register on the clk after the strobe.
//
// The slave modport is the bridge. The master modport is the SPI host together
// with the register file.
interface spi_reg_bridge_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  spi_ss_n;
  logic                  spi_sclk;
  logic                  spi_mosi;
  logic                  spi_miso;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic                  reg_en;
  logic                  reg_wr;
  logic [1:0]            reg_be;
  logic [15:0]           reg_d;
  logic [15:0]           reg_q;

  modport slave (
    input  spi_ss_n, spi_sclk, spi_mosi, reg_q,
    output spi_miso, reg_addr, reg_en, reg_wr, reg_be, reg_d
  );

  modport master (
    output spi_ss_n, spi_sclk, spi_mosi, reg_q,
    input  spi_miso, reg_addr, reg_en, reg_wr, reg_be, reg_d
  );
endinterface

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave that turns host frames into 16-bit
// register-bus accesses. The SPI pins are oversampled on clk.
// Frame layout: a command byte {rw, addr}, then data bytes sent low byte first.
// Optional feature: define SPI_REG_BRIDGE_AUTOINC_EN to step reg_addr after
// every write strobe and before every read fetch except the first one.
// dbg_state exposes the FSM state.
module spi_reg_bridge #(
  parameter int ADDR_WIDTH  = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  spi_reg_bridge_if.slave  bus,
  output logic [2:0]       dbg_state
);
  typedef enum logic [2:0] {IDLE, CMD, WR_LO, WR_HI, RD_FETCH, RD_LO, RD_HI} state_e;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
`endif

  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   ss_prev_q, sclk_prev_q;
  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             rx_q, rx_d;
  logic [15:0]            tx_q, tx_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   reg_en_q, reg_en_d;
  logic                   reg_wr_q, reg_wr_d;
  logic [1:0]             reg_be_q, reg_be_d;
  logic [15:0]            reg_d_q, reg_d_d;

  logic       ss_cur, sclk_cur, mosi_cur;
  logic       ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [7:0] byte_in;
  logic       byte_done;

  // Shift each SPI pin into its synchronizer chain; the MSB is the synced value.
  always_comb begin
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], bus.spi_ss_n};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
  end

  assign ss_cur    = ss_sync_q[SYNC_STAGES-1];
  assign sclk_cur  = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_cur  = mosi_sync_q[SYNC_STAGES-1];
  assign ss_fall   = ss_prev_q & ~ss_cur;
  assign ss_rise   = ~ss_prev_q & ss_cur;
  assign sclk_rise = sclk_cur & ~sclk_prev_q;
  assign sclk_fall = ~sclk_cur & sclk_prev_q;
  assign byte_in   = {rx_q, mosi_cur};
  assign byte_done = sclk_rise && (bit_cnt_q == 3'd7) && (state_q != IDLE);

  // FSM next state, serial shifting and register-bus strobe generation.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    reg_en_d  = 1'b0;
    reg_wr_d  = 1'b0;
    reg_be_d  = 2'b00;
    reg_d_d   = reg_d_q;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
    // Step the address on the clk after a write strobe.
    if (reg_en_q && reg_wr_q) addr_d = addr_q + ADDR_ONE;
`endif

    if (state_q != IDLE && sclk_rise) begin
      rx_d      = byte_in[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
    end

    // The word's first bit is already on MISO right after the capture. So the
    // falling edge that closes the previous byte must not shift it away.
    if (sclk_fall && (state_q == RD_HI || (state_q == RD_LO && bit_cnt_q != 3'd0))) begin
      tx_d = {tx_q[14:0], 1'b0};
    end

    case (state_q)
      IDLE: begin
        bit_cnt_d = 3'd0;
        tx_d      = '0;
        if (ss_fall) state_d = CMD;
      end
      CMD: begin
        if (byte_done) begin
          addr_d = byte_in[ADDR_WIDTH-1:0];
          if (byte_in[7]) begin
            state_d  = RD_FETCH;
            reg_en_d = 1'b1;
          end else begin
            state_d = WR_LO;
          end
        end
      end
      WR_LO: begin
        if (byte_done) begin
          reg_d_d[7:0] = byte_in;
          state_d      = WR_HI;
        end
      end
      WR_HI: begin
        if (byte_done) begin
          reg_d_d[15:8] = byte_in;
          reg_en_d      = 1'b1;
          reg_wr_d      = 1'b1;
          reg_be_d      = 2'b11;
          state_d       = WR_LO;
        end
      end
      RD_FETCH: begin
        // First cycle: strobe on the bus. Second cycle: reg_q is valid.
        if (!reg_en_q) begin
          tx_d    = {reg_q_lo_first(bus.reg_q)};
          state_d = RD_LO;
        end
      end
      RD_LO: begin
        if (byte_done) state_d = RD_HI;
      end
      RD_HI: begin
        if (byte_done) begin
          reg_en_d = 1'b1;
          state_d  = RD_FETCH;
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
          addr_d   = addr_q + ADDR_ONE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // End of frame: drop any partial byte. A completed low byte with no
    // high-byte bits becomes a low-byte-only write.
    if (state_q != IDLE && ss_rise) begin
      state_d   = IDLE;
      bit_cnt_d = 3'd0;
      tx_d      = '0;
      reg_en_d  = 1'b0;
      reg_wr_d  = 1'b0;
      reg_be_d  = 2'b00;
      if (state_q == WR_HI && bit_cnt_q == 3'd0) begin
        reg_en_d = 1'b1;
        reg_wr_d = 1'b1;
        reg_be_d = 2'b01;
      end
    end
  end

  // Put the low byte first so that MSB-first shifting sends q[7:0] before q[15:8].
  function automatic logic [15:0] reg_q_lo_first(input logic [15:0] q);
    return {q[7:0], q[15:8]};
  endfunction

  // State, shift and output registers. Synchronous reset.
  // The ss_n chain resets low, so the frame that reset interrupted cannot restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      ss_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      rx_q        <= '0;
      tx_q        <= '0;
      addr_q      <= '0;
      reg_en_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_be_q    <= 2'b00;
      reg_d_q     <= '0;
    end else begin
      ss_sync_q   <= ss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_prev_q   <= ss_cur;
      sclk_prev_q <= sclk_cur;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      reg_en_q    <= reg_en_d;
      reg_wr_q    <= reg_wr_d;
      reg_be_q    <= reg_be_d;
      reg_d_q     <= reg_d_d;
    end
  end

  assign bus.spi_miso = tx_q[15];
  assign bus.reg_addr = addr_q;
  assign bus.reg_en   = reg_en_q;
  assign bus.reg_wr   = reg_wr_q;
  assign bus.reg_be   = reg_be_q;
  assign bus.reg_d    = reg_d_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge. It runs directed frames and then random frames.
// A word-level model predicts the register-bus accesses and the MISO bytes.
module tb_spi_reg_bridge;
  localparam int W    = 26;  // {wr, be, addr[6:0], d[15:0]}
  localparam int HALF = 8;   // sclk half period in clk cycles
`ifdef SPI_REG_BRIDGE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  logic [15:0]  tb_mem  [128];  // register file stand-in driven by the bus
  logic [15:0]  ref_mem [128];  // model's view of the register contents
  logic [W-1:0] exp_q[$];
  logic [7:0]   exp_rx[$];
  logic [7:0]   frame_bytes[$];
  logic [7:0]   last_hi;
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  int           last_en_cyc = -100;

  // clock / reset
  always #5 clk = ~clk;

  spi_reg_bridge_if #(.ADDR_WIDTH(7)) bus ();

  spi_reg_bridge #(.ADDR_WIDTH(7), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // Register file: applies writes and returns read data one clk after the strobe.
  always @(posedge clk) begin
    if (bus.reg_en) begin
      if (bus.reg_wr) begin
        if (bus.reg_be[0]) tb_mem[bus.reg_addr][7:0]  <= bus.reg_d[7:0];
        if (bus.reg_be[1]) tb_mem[bus.reg_addr][15:8] <= bus.reg_d[15:8];
      end else begin
        bus.reg_q <= tb_mem[bus.reg_addr];
      end
    end
  end

  // Scoreboard: each strobe must match the next expected access and keep its spacing.
  always @(negedge clk) begin
    logic [W-1:0] obs;
    cyc++;
    if (bus.reg_en) begin
      obs = {bus.reg_wr, bus.reg_wr ? bus.reg_be : 2'b00, bus.reg_addr,
             bus.reg_wr ? bus.reg_d : 16'h0000};
      check_eq("strobe_gap", (cyc - last_en_cyc) >= 8, 1);
      check_eq("strobe_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check_eq("strobe", obs, exp_q.pop_front());
      last_en_cyc = cyc;
    end
  end

  // Model: frame_bytes[0] is the command, followed by n_full-1 complete data bytes.
  // extra = number of trailing bits before ss_n rises.
  task automatic model_frame(input int n_full, input int extra);
    logic [7:0]  cmd;
    logic [6:0]  a, fa;
    logic [15:0] d;
    int          words;
    if (n_full == 0) return;
    cmd   = frame_bytes[0];
    a     = cmd[6:0];
    words = (n_full - 1) / 2;
    if (cmd[7]) begin
      for (int w = 0; w <= words; w++) begin
        fa = 7'(int'(a) + (AUTOINC ? w : 0));
        exp_q.push_back({1'b0, 2'b00, fa, 16'h0000});
        if (2 * w     < n_full - 1) exp_rx.push_back(ref_mem[fa][7:0]);
        if (2 * w + 1 < n_full - 1) exp_rx.push_back(ref_mem[fa][15:8]);
      end
    end else begin
      for (int w = 0; w < words; w++) begin
        fa = 7'(int'(a) + (AUTOINC ? w : 0));
        d  = {frame_bytes[2 * w + 2], frame_bytes[2 * w + 1]};
        exp_q.push_back({1'b1, 2'b11, fa, d});
        ref_mem[fa] = d;
        last_hi     = d[15:8];
      end
      if (((n_full - 1) % 2) == 1 && extra == 0) begin
        fa = 7'(int'(a) + (AUTOINC ? words : 0));
        d  = {last_hi, frame_bytes[n_full - 1]};
        exp_q.push_back({1'b1, 2'b01, fa, d});
        ref_mem[fa][7:0] = d[7:0];
      end
    end
  endtask

  // driver tasks
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_mosi = tx[i];
      wait_clks(HALF);
      bus.spi_sclk = 1'b1;
      rx[i] = bus.spi_miso;
      wait_clks(HALF);
      bus.spi_sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input int n_full, input int extra);
    logic [7:0] rx;
    logic [7:0] want;
    model_frame(n_full, extra);
    bus.spi_ss_n = 1'b0;
    wait_clks(HALF);
    for (int i = 0; i < n_full; i++) begin
      spi_xfer(frame_bytes[i], 8, rx);
      if (i > 0 && frame_bytes[0][7]) begin
        want = (exp_rx.size() > 0) ? exp_rx.pop_front() : 8'hxx;
        check_eq("miso_byte", rx, want);
      end
    end
    if (extra > 0) spi_xfer(frame_bytes[n_full], extra, rx);
    wait_clks(HALF);
    bus.spi_ss_n = 1'b1;
    wait_clks(3 * HALF);
    check_eq("frame_drained", exp_q.size(), 0);
  endtask

  // watchdog
  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rx;
    bus.spi_ss_n = 1'b1;
    bus.spi_sclk = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.reg_q    = 16'h0000;
    last_hi      = 8'h00;
    for (int i = 0; i < 128; i++) begin
      tb_mem[i]  = 16'($urandom);
      ref_mem[i] = tb_mem[i];
    end

    // reset
    reset = 1'b1;
    wait_clks(3);
    reset = 1'b0;
    wait_clks(1);
    check_eq("rst_en",   bus.reg_en,   0);
    check_eq("rst_be",   bus.reg_be,   0);
    check_eq("rst_d",    bus.reg_d,    0);
    check_eq("rst_addr", bus.reg_addr, 0);
    check_eq("rst_miso", bus.spi_miso, 0);
    wait_clks(4 * HALF);

    // full write, partial write, read back, empty frame, burst with wrap
    frame_bytes = {8'h05, 8'hAD, 8'hDE};                 run_frame(3, 0);
    frame_bytes = {8'h06, 8'hEF};                        run_frame(2, 0);
    frame_bytes = {8'h05, 8'hEF, 8'hBE};                 run_frame(3, 0);
    frame_bytes = {8'h85, 8'h00, 8'hFF};                 run_frame(3, 0);
    frame_bytes = {8'h00};                               run_frame(0, 0);
    frame_bytes = {8'h7F, 8'hCE, 8'hFA, 8'hFE, 8'hCA};   run_frame(5, 0);
    frame_bytes = {8'hFF, 8'h5A, 8'hA5, 8'h3C, 8'hC3};   run_frame(5, 0);

    // reset in the middle of the high byte, then more clocks while ss_n stays low
    bus.spi_ss_n = 1'b0;
    wait_clks(HALF);
    spi_xfer(8'h03, 8, rx);
    spi_xfer(8'h11, 8, rx);
    spi_xfer(8'h22, 4, rx);
    reset = 1'b1;
    wait_clks(2);
    reset   = 1'b0;
    last_hi = 8'h00;
    wait_clks(1);
    check_eq("abort_en",   bus.reg_en,   0);
    check_eq("abort_d",    bus.reg_d,    0);
    check_eq("abort_addr", bus.reg_addr, 0);
    spi_xfer(8'h22, 4, rx);
    spi_xfer(8'h12, 8, rx);
    spi_xfer(8'h34, 8, rx);
    wait_clks(HALF);
    bus.spi_ss_n = 1'b1;
    wait_clks(3 * HALF);
    check_eq("abort_drained", exp_q.size(), 0);
    frame_bytes = {8'h01, 8'h0D, 8'hF0};                 run_frame(3, 0);

    // random frames: random command, length and trailing bits
    for (int f = 0; f < 24; f++) begin
      int n;
      int ex;
      frame_bytes.delete();
      n  = $urandom_range(0, 5);
      ex = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 7);
      for (int i = 0; i <= n; i++) frame_bytes.push_back(8'($urandom));
      run_frame(n, ex);
    end

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- SPI slave (mode 0, MSB-first) that turns host-MCU serial transactions into single-cycle 16-bit register-bus accesses with byte enables.
- Sits directly upstream of the register file. It drives each register's en/be/d and reads back the selected q.
- All SPI inputs are oversampled on the system clock; there is no second clock domain.

Parameters:
- ADDR_WIDTH, 7, register address width. Must be 1..7; address bits above ADDR_WIDTH-1 in the command byte are ignored.
- SYNC_STAGES, 2, synchronizer depth for spi_ss_n, spi_sclk and spi_mosi. Minimum 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- spi_ss_n  in  1  slave select, active low
- spi_sclk  in  1  SPI clock; at most clk/8
- spi_mosi  in  1  serial data from host
- spi_miso  out  1  serial data to host
- reg_addr  out  ADDR_WIDTH  register address
- reg_en  out  1  access strobe, one clk wide
- reg_wr  out  1  1 = write, 0 = read; valid while reg_en=1
- reg_be  out  2  {hi, lo} byte enables; valid on writes
- reg_d  out  16  write data
- reg_q  in  16  read data from the addressed register

Behaviour:
- Reset values: spi_miso=0, reg_en=0, reg_wr=0, reg_be=2'b00, reg_d=0, reg_addr=0, FSM=IDLE, bit counter=0.
- Input sampling:
  - Each SPI input passes through SYNC_STAGES flops.
  - A rising sclk edge is detected one clk after the last sync stage; MOSI is sampled on that edge.
  - MISO changes on the detected falling sclk edge. The first MISO bit of each byte is presented when the byte's bit counter is 0.
- Frame: the frame starts when ss_n falls and ends when ss_n rises.
  - Byte 0 is the command: bit7 = rw (1 = read), bits 6:0 = address.
  - The following bytes are data, low byte first, then high byte, repeating per 16-bit word.
- FSM states: IDLE, CMD, WR_LO, WR_HI, RD_FETCH, RD_LO, RD_HI.
- IDLE -> CMD on synced ss_n falling.
- CMD, after 8 bits:
  - Latch the address.
  - rw=0 -> WR_LO.
  - rw=1 -> RD_FETCH.
- WR_LO, after 8 bits: hold the byte in reg_d[7:0] -> WR_HI.
- WR_HI, after 8 bits:
  - Load reg_d[15:8].
  - Next clk: reg_en=1, reg_wr=1, reg_be=2'b11 for exactly one cycle.
  - Address then advances (see Optional Feature) -> WR_LO.
- RD_FETCH:
  - reg_en=1, reg_wr=0 for one clk.
  - reg_q is captured into the 16-bit shift register on the following clk (1-cycle register-file latency).
  - Then -> RD_LO.
  - This completes well before the next sclk edge, given the clk/8 limit.
- RD_LO: shift out q[7:0] MSB-first -> RD_HI.
- RD_HI, after q[15:8] is shifted out:
  - Advance the address and perform the next fetch -> RD_LO. The next word is prefetched, so continuous streaming needs no host gaps.
- ss_n rise (any state) -> IDLE, bit counter cleared, partial byte discarded. Exceptions:
  - If the FSM is in WR_HI with 0 bits received (low byte complete, high byte not started), issue one write with reg_be=2'b01, reg_d[15:8] unchanged from the previous value.
  - ss_n rise during RD_FETCH completes the fetch strobe; the captured data is discarded.
- Address wrap: the increment is modulo 2^ADDR_WIDTH (all-ones -> 0).
- ss_n low for 0 full bytes: no bus access.
- reset asserted mid-frame:
  - All outputs return to reset values on the next clk, with no partial write.
  - The FSM stays in IDLE until ss_n is seen high and then low again.
- reg_en is never asserted for more than one consecutive clk. Consecutive strobes are at least 8 clk apart.

Optional Feature:
- Macro: SPI_REG_BRIDGE_AUTOINC_EN.
- Defined: after every write strobe and every read fetch except the first fetch of a frame, reg_addr increments by 1 (wraps).
- Undefined: reg_addr stays at the command address for the whole frame. Repeated words hit the same register (port/FIFO-style access); the increment logic is not synthesized.

Test Plan:
1. Reset: assert reset for 1 clk -> reg_en=0, reg_be=00, reg_d=0000, reg_addr=0, spi_miso=0.
2. Write: frame 0x05, 0xAD, 0xDE -> one strobe: reg_addr=5, reg_wr=1, reg_be=11, reg_d=DEAD. No other reg_en pulses.
3. Partial write: frame 0x06, 0xEF, then ss_n high -> one strobe: reg_addr=6, reg_be=01, reg_d[7:0]=EF.
4. Read: frame 0x85 with reg_q=BEEF at addr 5 -> fetch strobe with reg_wr=0; MISO returns 0xEF then 0xBE.
5. Burst with AUTOINC_EN defined: frame 0x7F, CE,FA, FE,CA -> writes FACE@0x7F, CAFE@0x00 (wrap).
   - Without the macro, the same frame writes both words to 0x7F.
6. Abort: reset high after 4 bits of the high byte in WR_HI -> no reg_en pulse. A following clean write frame 0x01, 0x0D, 0xF0 -> writes F00D@1.
